// File: rtl/foo_arb_pkg.sv
// Shared types and operand encoding for the foo accumulator arbiter.
// Datapath computes x_next = x + a + 1, so every opcode is expressed through a.
package foo_arb_pkg;

    localparam int unsigned DATA_W = 64;
    localparam logic [DATA_W-1:0] IDLE_A = '1;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        ADD   = 2'd1,
        CLEAR = 2'd2,
        RSVD  = 2'd3
    } op_e;

    // a = -1 holds x, a = data-1 adds data, a = ~x lands on zero
    function automatic logic [DATA_W-1:0] encode_a(
        input op_e               op,
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] x
    );
        logic [DATA_W-1:0] a;
        a = IDLE_A;
        case (op)
            ADD:     a = data - DATA_W'(1);
            CLEAR:   a = ~x;
            default: a = IDLE_A;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/foo_rr_arbiter.sv
// Round-robin arbiter: first valid index at or above the pointer, wrapping.
// The pointer moves to winner+1 whenever anything is granted.
module foo_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_win_id,
    output logic               o_any
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_win;
    logic            w_any;
    int              w_idx;

    // Scan from the farthest slot back to the pointer so the last hit is the first in order
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= int'(NUM_REQ)) begin
                w_idx = w_idx - int'(NUM_REQ);
            end
            if (i_valid[ID_W'(w_idx)]) begin
                w_win = ID_W'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    assign o_grant  = w_any ? (NUM_REQ'(1) << w_win) : '0;
    assign o_win_id = w_win;
    assign o_any    = w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
        end
    end

endmodule

// File: rtl/foo_arb.sv
// Arbitrates requesters onto the shared foo accumulator and returns the post-op
// value one cycle after acceptance; also drives the datapath to zero during reset.
module foo_arb
    import foo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned CNT_W   = 32,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [DATA_W*NUM_REQ-1:0]  req_data,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [DATA_W-1:0]          dp_a,
    input  logic [DATA_W-1:0]          dp_x,
    output logic [CNT_W-1:0]           issue_count
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_accept;
    op_e                w_op;
    logic [DATA_W-1:0]  w_data;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_issue_count;

    foo_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (req_valid),
        .o_grant  (w_grant),
        .o_win_id (w_win),
        .o_any    (w_any)
    );

    assign w_accept  = w_any & ~rst;
    assign req_ready = rst ? '0 : w_grant;
    assign w_op      = op_e'(req_op[32'(w_win)*2 +: 2]);
    assign w_data    = req_data[32'(w_win)*DATA_W +: DATA_W];

    // Reset reuses the CLEAR encoding so the unreset datapath settles to zero
    always_comb begin
        dp_a = IDLE_A;
        if (rst) begin
            dp_a = ~dp_x;
        end else if (w_any) begin
            dp_a = encode_a(w_op, w_data, dp_x);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_err     <= 1'b0;
            r_issue_count <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_id      <= w_win;
                r_rsp_err     <= (w_op == RSVD);
                r_issue_count <= r_issue_count + CNT_W'(1);
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_err     = r_rsp_err;
    assign rsp_data    = r_rsp_valid ? dp_x : '0;
    assign issue_count = r_issue_count;

endmodule
